// File: rtl/led_pkg.sv
// Shared constants and state encoding for the LED pulse meter and its pulse generator.
package led_pkg;

  localparam int DEF_T_PERIOD = 2_000_001;
  localparam int DEF_T_HIGH   = 500_000;
  localparam int DEF_TOL      = 16;
  localparam int DEF_TIMEOUT  = 4_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Unsigned distance computed as max-min so it never wraps.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input plus a third flop for one-cycle rise/fall flags.
module sync_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Rise,
  output logic Fall
);

  logic [2:0] sync_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], D};
    end
  end

  assign Rise = sync_reg[1] & ~sync_reg[2];
  assign Fall = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/led_pulse_meter.sv
// Measures high time and rise-to-rise period of a pulse train, checks them against
// expected values within a tolerance, tracks lock and flags missing edges.
module led_pulse_meter
  import led_pkg::*;
#(
  parameter int T_PERIOD = DEF_T_PERIOD,
  parameter int T_HIGH   = DEF_T_HIGH,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_N   = 3,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CW       = 22
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Pulse_In,
  output logic [CW-1:0] High_Count,
  output logic [CW-1:0] Period_Count,
  output logic          Meas_Valid,
  output logic          Match,
  output logic          Lock,
  output logic          Timeout_Err
);

  localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  logic          rise;
  logic          fall;
  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] high_reg;
  logic [MW-1:0] match_cnt_reg;
  logic [MW-1:0] match_cnt_next;
  logic          accept_rise;
  logic          accept_fall;
  logic          timeout;
  logic          meas_match;

  sync_edge_det u_sync_edge_det (
    .CLK  (CLK),
    .RST  (RST),
    .D    (Pulse_In),
    .Rise (rise),
    .Fall (fall)
  );

  assign accept_rise = rise && (state_reg != ST_HIGH);
  assign accept_fall = fall && (state_reg == ST_HIGH);
  // Using >= keeps the counter bounded even if an edge lands exactly on TIMEOUT.
  assign timeout     = (cnt_reg >= CW'(TIMEOUT)) && !accept_rise && !accept_fall;

  // Evaluated on the values that are about to be published.
  assign meas_match = (abs_diff(32'(high_reg), 32'(T_HIGH))  <= 32'(TOL)) &&
                      (abs_diff(32'(cnt_reg),  32'(T_PERIOD)) <= 32'(TOL));

  always_comb begin
    match_cnt_next = '0;
    if (meas_match) begin
      match_cnt_next = (match_cnt_reg == MW'(LOCK_N)) ? match_cnt_reg : match_cnt_reg + MW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      high_reg      <= '0;
      match_cnt_reg <= '0;
      High_Count    <= '0;
      Period_Count  <= '0;
      Meas_Valid    <= 1'b0;
      Match         <= 1'b0;
      Lock          <= 1'b0;
      Timeout_Err   <= 1'b0;
    end else begin
      Meas_Valid  <= 1'b0;
      Timeout_Err <= 1'b0;
      cnt_reg     <= cnt_reg + CW'(1);
      if (timeout) begin
        state_reg     <= ST_IDLE;
        cnt_reg       <= '0;
        match_cnt_reg <= '0;
        Lock          <= 1'b0;
        Timeout_Err   <= 1'b1;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (accept_rise) begin
              state_reg <= ST_HIGH;
              cnt_reg   <= CW'(1);
            end
          end
          ST_HIGH: begin
            if (accept_fall) begin
              state_reg <= ST_LOW;
              high_reg  <= cnt_reg;
            end
          end
          ST_LOW: begin
            if (accept_rise) begin
              state_reg     <= ST_HIGH;
              cnt_reg       <= CW'(1);
              Period_Count  <= cnt_reg;
              High_Count    <= high_reg;
              Meas_Valid    <= 1'b1;
              Match         <= meas_match;
              match_cnt_reg <= match_cnt_next;
              Lock          <= (match_cnt_next == MW'(LOCK_N));
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_pulse_meter.sv
// Directed bench for led_pulse_meter with small timing parameters and hand-computed results.
module tb_led_pulse_meter;

  localparam int CW = 22;

  logic          CLK;
  logic          RST;
  logic          Pulse_In;
  logic [CW-1:0] High_Count;
  logic [CW-1:0] Period_Count;
  logic          Meas_Valid;
  logic          Match;
  logic          Lock;
  logic          Timeout_Err;

  typedef struct {
    int h;
    int p;
    int m;
    int l;
  } ev_t;

  ev_t evq[$];
  int  to_cnt = 0;
  int  checks = 0;
  int  passes = 0;

  led_pulse_meter #(
    .T_PERIOD (100),
    .T_HIGH   (25),
    .TOL      (2),
    .LOCK_N   (3),
    .TIMEOUT  (300),
    .CW       (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .Pulse_In     (Pulse_In),
    .High_Count   (High_Count),
    .Period_Count (Period_Count),
    .Meas_Valid   (Meas_Valid),
    .Match        (Match),
    .Lock         (Lock),
    .Timeout_Err  (Timeout_Err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One line per published measurement or timeout.
  always @(negedge CLK) begin
    if (Meas_Valid) begin
      evq.push_back('{h: int'(High_Count), p: int'(Period_Count), m: int'(Match), l: int'(Lock)});
      $display("meas high=%0d period=%0d match=%0b lock=%0b", High_Count, Period_Count, Match, Lock);
    end
    if (Timeout_Err) begin
      to_cnt++;
      $display("timeout high=%0d period=%0d lock=%0b", High_Count, Period_Count, Lock);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic expect_ev(input string tag, input int h, input int p, input int m, input int l);
    ev_t e;
    chk({tag, "_present"}, (evq.size() > 0) ? 1 : 0, 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      chk({tag, "_high"},   e.h, h);
      chk({tag, "_period"}, e.p, p);
      chk({tag, "_match"},  e.m, m);
      chk({tag, "_lock"},   e.l, l);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_high_count"},   int'(High_Count),   0);
    chk({tag, "_period_count"}, int'(Period_Count), 0);
    chk({tag, "_meas_valid"},   int'(Meas_Valid),   0);
    chk({tag, "_match"},        int'(Match),        0);
    chk({tag, "_lock"},         int'(Lock),         0);
    chk({tag, "_timeout_err"},  int'(Timeout_Err),  0);
  endtask

  task automatic pulse(input int h, input int l);
    Pulse_In = 1'b1;
    repeat (h) @(negedge CLK);
    Pulse_In = 1'b0;
    repeat (l) @(negedge CLK);
  endtask

  initial begin
    RST      = 1'b1;
    Pulse_In = 1'b0;
    repeat (3) @(negedge CLK);
    chk_zero("reset");
    RST = 1'b0;
    repeat (5) @(negedge CLK);

    // Four nominal periods: three strobes, lock on the third.
    repeat (4) pulse(25, 75);
    chk("nominal_count", evq.size(), 3);
    expect_ev("nom1", 25, 100, 1, 0);
    expect_ev("nom2", 25, 100, 1, 0);
    expect_ev("nom3", 25, 100, 1, 1);

    // One long-high period breaks lock; three good ones restore it.
    pulse(30, 70);
    repeat (4) pulse(25, 75);
    chk("relock_count", evq.size(), 5);
    expect_ev("nom4",    25, 100, 1, 1);
    expect_ev("bad_hi",  30, 100, 0, 0);
    expect_ev("relock1", 25, 100, 1, 0);
    expect_ev("relock2", 25, 100, 1, 0);
    expect_ev("relock3", 25, 100, 1, 1);

    // Tolerance edges: 27/102 inside, 28 high and 103 period outside.
    pulse(27, 75);
    pulse(28, 72);
    pulse(25, 78);
    repeat (3) pulse(25, 75);
    chk("bound_count", evq.size(), 6);
    expect_ev("pre_bound", 25, 100, 1, 1);
    expect_ev("b27_102",   27, 102, 1, 1);
    expect_ev("b28",       28, 100, 0, 0);
    expect_ev("b103",      25, 103, 0, 0);
    expect_ev("bgood1",    25, 100, 1, 0);
    expect_ev("bgood2",    25, 100, 1, 0);
    chk("no_timeout_yet", to_cnt, 0);

    // Locked, then the input stays low long enough for exactly one timeout.
    pulse(25, 340);
    chk("to_phase_count", evq.size(), 1);
    expect_ev("pre_to", 25, 100, 1, 1);
    chk("to_once",       to_cnt, 1);
    chk("to_lock",       int'(Lock), 0);
    chk("to_hold_high",  int'(High_Count), 25);
    chk("to_hold_per",   int'(Period_Count), 100);

    // After timeout the first rise must not publish.
    pulse(25, 75);
    chk("post_to_first_rise", evq.size(), 0);
    Pulse_In = 1'b1;
    repeat (10) @(negedge CLK);
    expect_ev("post_to", 25, 100, 1, 0);

    // Reset for two cycles in the middle of a high phase.
    RST      = 1'b1;
    Pulse_In = 1'b0;
    @(negedge CLK);
    chk_zero("midrst1");
    @(negedge CLK);
    RST = 1'b0;
    chk_zero("midrst2");
    repeat (20) @(negedge CLK);
    pulse(25, 75);
    chk("post_rst_first_rise", evq.size(), 0);
    Pulse_In = 1'b1;
    repeat (10) @(negedge CLK);
    expect_ev("post_rst", 25, 100, 1, 0);
    chk("to_total", to_cnt, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/led_pulse_meter.md
LED_PULSE_METER -- requirements
Module: led_pulse_meter

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- T_PERIOD, 2_000_001, expected rise-to-rise period in CLK cycles.
- T_HIGH, 500_000, expected rise-to-fall high time in CLK cycles.
- TOL, 16, allowed absolute deviation for both measurements.
- LOCK_N, 3, consecutive matching periods required for lock.
- TIMEOUT, 4_000_000, cycles without an edge before an error is flagged.
- CW, 22, counter and result width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  single system clock; all logic rises on it.
- RST  in  1  reset, synchronous and active-high.
- Pulse_In  in  1  asynchronous LED-style pulse to be measured.
- High_Count  out  CW  last measured high time.
- Period_Count  out  CW  last measured period.
- Meas_Valid  out  1  one-cycle strobe when both counts update.
- Match  out  1  last measurement within tolerance; valid with Meas_Valid.
- Lock  out  1  level: LOCK_N consecutive matches seen.
- Timeout_Err  out  1  one-cycle strobe on edge timeout.

Function
REQ-003 Pulse_In SHALL pass through a two-flop synchronizer; a third flop SHALL give rise/fall flags, each one cycle wide.
REQ-004 The FSM SHALL have three states:
- IDLE: waits for a rise.
- HIGH: counts until a fall.
- LOW: counts until the next rise.
REQ-005 The FSM transitions SHALL be:
- IDLE, rise -> HIGH.
- HIGH, fall -> LOW.
- LOW, rise -> HIGH, and a measurement is published.
- A rise in HIGH, or a fall in IDLE/LOW, SHALL be ignored.
REQ-006 The cycle counter SHALL be loaded with 1 on the cycle after each accepted rise and increment by 1 every cycle thereafter.
REQ-007 Counts SHALL be latched as follows:
- At the accepted fall, the high time (counter value) SHALL be latched internally.
- At the next accepted rise, Period_Count SHALL equal the counter value.
- The latched high time SHALL then be copied to High_Count.
- Both counts SHALL therefore measure distances between detected edges, so synchronizer latency cancels.
REQ-008 Meas_Valid and Match SHALL assert in the cycle after the publishing rise, when High_Count and Period_Count are already updated.
REQ-009 Match SHALL be 1 iff |High_Count - T_HIGH| <= TOL and |Period_Count - T_PERIOD| <= TOL.
- Differences SHALL be computed unsigned as max-min, with no wrap.
REQ-010 A match counter SHALL behave as follows:
- It increments on each matching measurement and saturates at LOCK_N.
- Lock SHALL be 1 while the counter equals LOCK_N.
- A mismatch SHALL clear the counter and Lock in the same cycle as Meas_Valid.
REQ-011 On timeout, if the counter reaches TIMEOUT in any state with no accepted edge in that cycle:
- Timeout_Err SHALL pulse for one cycle.
- The FSM SHALL go to IDLE.
- Lock and the match counter SHALL clear.
- The counter SHALL restart from 0.
- High_Count and Period_Count SHALL hold their values.
REQ-012 An accepted edge coinciding with the timeout cycle SHALL win; no Timeout_Err is issued.
REQ-013 The counter SHALL never wrap; TIMEOUT < 2^CW is a parameter constraint.
REQ-014 The first rise after IDLE SHALL NOT publish a measurement.

Reset
REQ-015 While RST=1 at a CLK edge, the block SHALL reset as follows:
- FSM = IDLE.
- Synchronizer flops, counters, High_Count and Period_Count = 0.
- Meas_Valid, Match, Lock and Timeout_Err = 0.
REQ-016 Reset mid-measurement SHALL discard the partial measurement; measurement restarts at the first rise after RST falls.
REQ-017 Edges detected during reset SHALL be ignored.

Structure
REQ-018 A shared package led_pkg SHALL hold the default T_PERIOD, T_HIGH, TOL and TIMEOUT constants and the state encoding.
- The same package SHALL be used by the pulse generator.
REQ-019 The synchronizer plus edge detector SHALL be one sub-module, sync_edge_det (ports CLK, RST, D, Rise, Fall).

Verification
Simulation parameters: T_PERIOD=100, T_HIGH=25, TOL=2, LOCK_N=3, TIMEOUT=300.
REQ-020 Pulse high 25 / low 75, repeated 4 times -> Meas_Valid 3 times with High_Count=25, Period_Count=100, Match=1; Lock rises on the 3rd strobe.
REQ-021 While locked, one period with high=30 -> Match=0 and Lock=0 on that strobe; Lock returns after 3 further good periods.
REQ-022 Boundary: high=27, period=102 -> Match=1; high=28 -> Match=0.
REQ-023 Pulse_In held low for 300 cycles after lock -> exactly one Timeout_Err, Lock=0, counts held; the next two rises publish only on the second.
REQ-024 RST asserted for 2 cycles mid-HIGH -> all outputs 0 next cycle; the first post-reset measurement appears only after two rises.
